// File: rtl/mem_vga_main.sv
// 640x480@60Hz VGA scan-out of a 160x120 RGB332 frame buffer (4x4 pixel replication).
// After reset the buffer is filled with mem[a] = a[7:0]; the picture stays blank until the fill is done.
module mem_vga_main #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2
) (
    input  logic       clk_in,
    input  logic       rst,
    output logic [7:0] rgb,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = $clog2(FB_SIZE);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {INIT, RUN} state_t;

    logic [DW-1:0] div;
    logic          pe;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          hs_n;
    logic          vs_n;
    logic          active;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_d1;
    logic          hs_d1;
    logic          vs_d1;
    logic          act_d1;
    state_t        state;
    logic [AW-1:0] init_addr;
    logic [7:0]    mem [FB_SIZE];

    assign pe = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pe) begin
            if (hcnt == 10'(H_TOTAL - 1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign hs_n   = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_n   = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
    assign active = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    // Out-of-range addresses during blanking are harmless: the read is gated by active.
    assign addr   = AW'(vcnt >> SCALE_SH) * AW'(FB_W) + AW'(hcnt >> SCALE_SH);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
        end else if (state == INIT) begin
            if (init_addr == AW'(FB_SIZE - 1)) begin
                state <= RUN;
            end else begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (state == INIT) begin
            mem[init_addr] <= 8'(init_addr);
        end
    end

    // Two pe stages: stage 1 registers address and raw timing, stage 2 is the RAM read and outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            addr_d1 <= '0;
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
            act_d1  <= 1'b0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            rgb     <= 8'h00;
        end else if (pe) begin
            addr_d1 <= addr;
            hs_d1   <= hs_n;
            vs_d1   <= vs_n;
            act_d1  <= active;
            hsync   <= hs_d1;
            vsync   <= vs_d1;
            rgb     <= (act_d1 && state == RUN) ? mem[addr_d1] : 8'h00;
        end
    end

endmodule

// File: tb/tb_mem_vga_main.sv
// Directed bench: full-size instance for line timing and fill pattern, reduced-geometry
// instance for frame timing, complete-frame contents and mid-frame reset.
module tb_mem_vga_main;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       rst_s  = 1'b1;
    logic [7:0] rgb;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb_s;
    logic       hsync_s;
    logic       vsync_s;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         cyc_s  = 0;

    mem_vga_main dut (
        .clk_in (clk_in),
        .rst    (rst),
        .rgb    (rgb),
        .hsync  (hsync),
        .vsync  (vsync)
    );

    // Reduced geometry: 48 px/line, 24 lines/frame, 8x4 buffer, 2 clocks per pixel.
    mem_vga_main #(
        .CLK_DIV (2),
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .FB_W    (8),  .FB_H(4), .SCALE_SH(2)
    ) dut_s (
        .clk_in (clk_in),
        .rst    (rst_s),
        .rgb    (rgb_s),
        .hsync  (hsync_s),
        .vsync  (vsync_s)
    );

    always #5 clk_in = ~clk_in;

    // Clock edges since reset release; edge n is the n-th rising edge with reset low.
    always @(posedge clk_in) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (rst_s) cyc_s <= 0;
        else       cyc_s <= cyc_s + 1;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic late(input string tag, input int now, input int target);
        errors++;
        $display("FAIL %s: sample point %0d already passed at edge %0d", tag, target, now);
    endtask

    // sel: 0 = rgb, 1 = hsync, 2 = vsync; sampled on the negedge after edge t.
    task automatic chk_d(input int t, input string tag, input int sel, input logic [7:0] exp);
        if (cyc > t) late(tag, cyc, t);
        while (cyc < t) @(negedge clk_in);
        case (sel)
            0:       check_val(tag, rgb, exp);
            1:       check_val(tag, {7'b0, hsync}, exp);
            default: check_val(tag, {7'b0, vsync}, exp);
        endcase
    endtask

    task automatic chk_s(input int t, input string tag, input int sel, input logic [7:0] exp);
        if (cyc_s > t) late(tag, cyc_s, t);
        while (cyc_s < t) @(negedge clk_in);
        case (sel)
            0:       check_val(tag, rgb_s, exp);
            1:       check_val(tag, {7'b0, hsync_s}, exp);
            default: check_val(tag, {7'b0, vsync_s}, exp);
        endcase
    endtask

    // Full-size: pixel k (pe count) appears after edge 4*(k+2); line 800 px, fill ends at edge 19200.
    task automatic full_seq();
        chk_d(2631,  "hs_before_fall",  1, 8'h01);
        chk_d(2632,  "hs_fall",         1, 8'h00);
        chk_d(3015,  "hs_last_low",     1, 8'h00);
        chk_d(3016,  "hs_rise",         1, 8'h01);
        chk_d(3224,  "init_y1_x4",      0, 8'h00);
        chk_d(5831,  "hs2_before_fall", 1, 8'h01);
        chk_d(5832,  "hs2_fall",        1, 8'h00);
        chk_d(16024, "init_y5_x4",      0, 8'h00);
        chk_d(19208, "run_y6_x0",       0, 8'hA0);
        chk_d(21768, "blank_y6_x640",   0, 8'h00);
        chk_d(22420, "y7_x3",           0, 8'hA0);
        chk_d(22424, "y7_x4",           0, 8'hA1);
        chk_d(28164, "y8_x639",         0, 8'hDF);
    endtask

    // Reduced: pixel k appears after edge 2*(k+2); frame is 1152 pixels, fill ends at edge 32.
    task automatic small_seq();
        chk_s(12,   "s_init_x4",       0, 8'h00);
        chk_s(75,   "s_hs_before",     1, 8'h01);
        chk_s(76,   "s_hs_fall",       1, 8'h00);
        chk_s(91,   "s_hs_last_low",   1, 8'h00);
        chk_s(92,   "s_hs_rise",       1, 8'h01);
        chk_s(1731, "s_vs_before",     2, 8'h01);
        chk_s(1732, "s_vs_fall",       2, 8'h00);
        chk_s(1923, "s_vs_last_low",   2, 8'h00);
        chk_s(1924, "s_vs_rise",       2, 8'h01);
        chk_s(2308, "s_f1_x0",         0, 8'h00);
        chk_s(2314, "s_f1_x3",         0, 8'h00);
        chk_s(2316, "s_f1_x4",         0, 8'h01);
        chk_s(2370, "s_f1_x31",        0, 8'h07);
        chk_s(2372, "s_f1_hblank",     0, 8'h00);
        chk_s(2692, "s_f1_y4_x0",      0, 8'h08);
        chk_s(3810, "s_f1_y15_x31",    0, 8'h1F);
        chk_s(3844, "s_f1_vblank",     0, 8'h00);
        chk_s(4035, "s_vs2_before",    2, 8'h01);
        chk_s(4036, "s_vs2_fall",      2, 8'h00);
        chk_s(4620, "s_f2_x4",         0, 8'h01);

        rst_s = 1'b1;
        #1;
        check_val("s_rst_rgb",   rgb_s,            8'h00);
        check_val("s_rst_hsync", {7'b0, hsync_s},  8'h01);
        check_val("s_rst_vsync", {7'b0, vsync_s},  8'h01);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_val("s_rst_hold_rgb", rgb_s, 8'h00);
        rst_s = 1'b0;

        chk_s(12, "s_re_init_x4",  0, 8'h00);
        chk_s(44, "s_re_x20",      0, 8'h05);
        chk_s(75, "s_re_hs_before", 1, 8'h01);
        chk_s(76, "s_re_hs_fall",  1, 8'h00);
    endtask

    initial begin
        #50;
        check_val("rst_rgb",     rgb,             8'h00);
        check_val("rst_hsync",   {7'b0, hsync},   8'h01);
        check_val("rst_vsync",   {7'b0, vsync},   8'h01);
        check_val("s_rst0_rgb",  rgb_s,           8'h00);
        check_val("s_rst0_hs",   {7'b0, hsync_s}, 8'h01);
        #50;
        rst   = 1'b0;
        rst_s = 1'b0;
        fork
            full_seq();
            small_seq();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
